icache_l1_sa: RTL and testbench



---
 rtl/icache_pkg.sv | 26 ++
 rtl/icache_way_select.sv | 48 ++++
 rtl/icache_l1_sa.sv | 227 ++++++++++++++++++++++
 tb/tb_icache_l1_sa.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared encodings for the set-associative L1 instruction cache:
// command codes, line states, controller states and L2 request codes.
package icache_pkg;

  localparam logic [2:0] CMD_FETCH     = 3'd0;
  localparam logic [2:0] CMD_SNOOP_INV = 3'd1;
  localparam logic [2:0] CMD_SNOOP_RD  = 3'd2;
  localparam logic [2:0] CMD_CLEAR     = 3'd3;

  localparam logic [1:0] L2_NONE = 2'd0;
  localparam logic [1:0] L2_READ = 2'd2;

  typedef enum logic [1:0] {
    LS_INVALID   = 2'd0,
    LS_SHARED    = 2'd1,
    LS_EXCLUSIVE = 2'd2
  } line_state_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOOKUP = 2'd1,
    S_AGE    = 2'd2,
    S_CLEAR  = 2'd3
  } fsm_state_e;

endpackage

// File: rtl/icache_way_select.sv
// Combinational hit detection and victim choice for one set.
// Victim is the lowest-index INVALID way, otherwise the LRU way (age WAYS-1).
module icache_way_select
  import icache_pkg::*;
#(
  parameter int TAG_W = 20,
  parameter int WAYS  = 4,
  parameter int WAY_W = $clog2(WAYS)
) (
  input  logic [TAG_W-1:0] tags       [WAYS],
  input  line_state_e      states     [WAYS],
  input  logic [WAY_W-1:0] ages       [WAYS],
  input  logic [TAG_W-1:0] lookup_tag,
  output logic             hit,
  output logic [WAY_W-1:0] hit_way,
  output logic [WAY_W-1:0] hit_age,
  output logic [WAY_W-1:0] victim_way,
  output logic [WAY_W-1:0] victim_age
);

  logic             have_inv;
  logic [WAY_W-1:0] inv_way;
  logic [WAY_W-1:0] lru_way;

  always_comb begin
    hit      = 1'b0;
    hit_way  = '0;
    hit_age  = '0;
    have_inv = 1'b0;
    inv_way  = '0;
    lru_way  = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!hit && states[w] != LS_INVALID && tags[w] == lookup_tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
        hit_age = ages[w];
      end
      if (!have_inv && states[w] == LS_INVALID) begin
        have_inv = 1'b1;
        inv_way  = WAY_W'(w);
      end
      if (ages[w] == WAY_W'(WAYS - 1)) lru_way = WAY_W'(w);
    end
    victim_way = have_inv ? inv_way : lru_way;
    victim_age = ages[victim_way];
  end

endmodule

// File: rtl/icache_l1_sa.sv
// Set-associative L1 instruction cache tag/state controller with true-LRU ages,
// snoop handling, a one-set-per-cycle clear walk and statistics counters.
module icache_l1_sa
  import icache_pkg::*;
#(
  parameter  int ADDR_W     = 32,
  parameter  int SETS       = 64,
  parameter  int WAYS       = 4,
  parameter  int LINE_BYTES = 64,
  parameter  int CNT_W      = 32,
  localparam int OFF_W      = $clog2(LINE_BYTES),
  localparam int IDX_W      = $clog2(SETS),
  localparam int WAY_W      = $clog2(WAYS),
  localparam int TAG_W      = ADDR_W - IDX_W - OFF_W,
  localparam int DBG_W      = TAG_W + 2 + WAY_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd,
  input  logic [ADDR_W-1:0] addr,
  output logic              l2_valid,
  output logic [1:0]        l2_cmd,
  output logic [ADDR_W-1:0] l2_addr,
  output logic [CNT_W-1:0]  hits,
  output logic [CNT_W-1:0]  misses,
  output logic [CNT_W-1:0]  fetches,
  output logic [CNT_W-1:0]  snoops,
  input  logic [IDX_W-1:0]  dbg_set,
  input  logic [WAY_W-1:0]  dbg_way,
  output logic [DBG_W-1:0]  dbg_line
);

  logic [TAG_W-1:0] tag_q [SETS][WAYS];
  logic [TAG_W-1:0] tag_d [SETS][WAYS];
  line_state_e      st_q  [SETS][WAYS];
  line_state_e      st_d  [SETS][WAYS];
  logic [WAY_W-1:0] age_q [SETS][WAYS];
  logic [WAY_W-1:0] age_d [SETS][WAYS];

  fsm_state_e        state_q, state_d;
  logic [2:0]        cmd_q, cmd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WAY_W-1:0]  sel_way_q, sel_way_d;
  logic [WAY_W-1:0]  sel_age_q, sel_age_d;
  logic [IDX_W-1:0]  clr_ptr_q, clr_ptr_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              l2_valid_q, l2_valid_d;
  logic [1:0]        l2_cmd_q, l2_cmd_d;
  logic [ADDR_W-1:0] l2_addr_q, l2_addr_d;
  logic [CNT_W-1:0]  hits_q, hits_d, misses_q, misses_d;
  logic [CNT_W-1:0]  fetches_q, fetches_d, snoops_q, snoops_d;
  logic [DBG_W-1:0]  dbg_line_q, dbg_line_d;

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] lk_tag;
  logic [TAG_W-1:0] set_tags [WAYS];
  line_state_e      set_st   [WAYS];
  logic [WAY_W-1:0] set_age  [WAYS];
  logic             hit;
  logic [WAY_W-1:0] hit_way, hit_age, victim_way, victim_age;

  assign idx    = addr_q[OFF_W +: IDX_W];
  assign lk_tag = addr_q[ADDR_W-1 -: TAG_W];

  always_comb begin
    for (int w = 0; w < WAYS; w++) begin
      set_tags[w] = tag_q[idx][w];
      set_st[w]   = st_q[idx][w];
      set_age[w]  = age_q[idx][w];
    end
  end

  icache_way_select #(
    .TAG_W (TAG_W),
    .WAYS  (WAYS),
    .WAY_W (WAY_W)
  ) u_way_select (
    .tags       (set_tags),
    .states     (set_st),
    .ages       (set_age),
    .lookup_tag (lk_tag),
    .hit        (hit),
    .hit_way    (hit_way),
    .hit_age    (hit_age),
    .victim_way (victim_way),
    .victim_age (victim_age)
  );

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    addr_d     = addr_q;
    sel_way_d  = sel_way_q;
    sel_age_d  = sel_age_q;
    clr_ptr_d  = clr_ptr_q;
    tag_d      = tag_q;
    st_d       = st_q;
    age_d      = age_q;
    l2_valid_d = 1'b0;
    l2_cmd_d   = L2_NONE;
    l2_addr_d  = l2_addr_q;
    hits_d     = hits_q;
    misses_d   = misses_q;
    fetches_d  = fetches_q;
    snoops_d   = snoops_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          cmd_d   = cmd;
          addr_d  = addr;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        state_d = S_IDLE;
        case (cmd_q)
          CMD_FETCH: begin
            fetches_d = fetches_q + CNT_W'(1);
            state_d   = S_AGE;
            if (hit) begin
              hits_d    = hits_q + CNT_W'(1);
              sel_way_d = hit_way;
              sel_age_d = hit_age;
            end else begin
              misses_d                 = misses_q + CNT_W'(1);
              sel_way_d                = victim_way;
              sel_age_d                = victim_age;
              tag_d[idx][victim_way]   = lk_tag;
              st_d[idx][victim_way]    = LS_EXCLUSIVE;
              l2_valid_d               = 1'b1;
              l2_cmd_d                 = L2_READ;
              l2_addr_d                = addr_q & ~ADDR_W'(LINE_BYTES - 1);
            end
          end
          CMD_SNOOP_INV: begin
            snoops_d = snoops_q + CNT_W'(1);
            if (hit) st_d[idx][hit_way] = LS_INVALID;
          end
          CMD_SNOOP_RD: begin
            snoops_d = snoops_q + CNT_W'(1);
            if (hit && st_q[idx][hit_way] == LS_EXCLUSIVE) st_d[idx][hit_way] = LS_SHARED;
          end
          CMD_CLEAR: begin
            state_d   = S_CLEAR;
            clr_ptr_d = '0;
          end
          default: ;
        endcase
      end
      S_AGE: begin
        // Promote the selected way to MRU; only ways younger than it shift down.
        for (int w = 0; w < WAYS; w++) begin
          if (WAY_W'(w) == sel_way_q) age_d[idx][w] = '0;
          else if (age_q[idx][w] < sel_age_q) age_d[idx][w] = age_q[idx][w] + WAY_W'(1);
        end
        state_d = S_IDLE;
      end
      S_CLEAR: begin
        for (int w = 0; w < WAYS; w++) begin
          tag_d[clr_ptr_q][w] = '0;
          st_d[clr_ptr_q][w]  = LS_INVALID;
          age_d[clr_ptr_q][w] = WAY_W'(WAYS - 1 - w);
        end
        if (clr_ptr_q == IDX_W'(SETS - 1)) state_d = S_IDLE;
        else clr_ptr_d = clr_ptr_q + IDX_W'(1);
      end
      default: state_d = S_CLEAR;
    endcase

    cmd_ready_d = (state_d == S_IDLE);
    dbg_line_d  = {tag_q[dbg_set][dbg_way], st_q[dbg_set][dbg_way], age_q[dbg_set][dbg_way]};
  end

  // Array flops only take updates out of reset, so the restarted walk sees no partial write.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_CLEAR;
      clr_ptr_q   <= '0;
      cmd_q       <= '0;
      addr_q      <= '0;
      sel_way_q   <= '0;
      sel_age_q   <= '0;
      cmd_ready_q <= 1'b0;
      l2_valid_q  <= 1'b0;
      l2_cmd_q    <= L2_NONE;
      l2_addr_q   <= '0;
      hits_q      <= '0;
      misses_q    <= '0;
      fetches_q   <= '0;
      snoops_q    <= '0;
      dbg_line_q  <= '0;
    end else begin
      state_q     <= state_d;
      clr_ptr_q   <= clr_ptr_d;
      cmd_q       <= cmd_d;
      addr_q      <= addr_d;
      sel_way_q   <= sel_way_d;
      sel_age_q   <= sel_age_d;
      cmd_ready_q <= cmd_ready_d;
      l2_valid_q  <= l2_valid_d;
      l2_cmd_q    <= l2_cmd_d;
      l2_addr_q   <= l2_addr_d;
      hits_q      <= hits_d;
      misses_q    <= misses_d;
      fetches_q   <= fetches_d;
      snoops_q    <= snoops_d;
      dbg_line_q  <= dbg_line_d;
      tag_q       <= tag_d;
      st_q        <= st_d;
      age_q       <= age_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign l2_valid  = l2_valid_q;
  assign l2_cmd    = l2_cmd_q;
  assign l2_addr   = l2_addr_q;
  assign hits      = hits_q;
  assign misses    = misses_q;
  assign fetches   = fetches_q;
  assign snoops    = snoops_q;
  assign dbg_line  = dbg_line_q;

endmodule

// File: tb/tb_icache_l1_sa.sv
// Directed bench for icache_l1_sa at default parameters; expected values are
// hand-derived from the LRU/victim rules and built with mk().
module tb_icache_l1_sa;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd;
  logic [31:0] addr;
  logic        l2_valid;
  logic [1:0]  l2_cmd;
  logic [31:0] l2_addr;
  logic [31:0] hits, misses, fetches, snoops;
  logic [5:0]  dbg_set;
  logic [1:0]  dbg_way;
  logic [23:0] dbg_line;

  int n_chk  = 0;
  int n_fail = 0;

  icache_l1_sa dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd       (cmd),
    .addr      (addr),
    .l2_valid  (l2_valid),
    .l2_cmd    (l2_cmd),
    .l2_addr   (l2_addr),
    .hits      (hits),
    .misses    (misses),
    .fetches   (fetches),
    .snoops    (snoops),
    .dbg_set   (dbg_set),
    .dbg_way   (dbg_way),
    .dbg_line  (dbg_line)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // {tag, state, age}; state 0=INVALID 1=SHARED 2=EXCLUSIVE
  function automatic logic [23:0] mk(input int t, input int s, input int a);
    return {t[19:0], s[1:0], a[1:0]};
  endfunction

  task automatic rd_dbg(input int s, input int w, output logic [23:0] v);
    dbg_set = s[5:0];
    dbg_way = w[1:0];
    @(negedge clk);
    v = dbg_line;
  endtask

  // Issue one command; lat = negedges from acceptance until cmd_ready is high again.
  task automatic issue(input logic [2:0] c, input logic [31:0] a, output int lat,
                       output bit seen, output logic [31:0] l2a, output logic [1:0] l2c);
    int n;
    n = 0;
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) check("ready_before_issue", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd       = c;
    addr      = a;
    @(negedge clk);
    cmd_valid = 1'b0;
    lat  = 1;
    seen = 1'b0;
    l2a  = '0;
    l2c  = '0;
    while (!cmd_ready && lat < 200) begin
      if (l2_valid) begin
        seen = 1'b1;
        l2a  = l2_addr;
        l2c  = l2_cmd;
      end
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic count_walk(output int n);
    n = 0;
    while (!cmd_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    int          lat, n;
    bit          seen;
    logic [31:0] l2a;
    logic [1:0]  l2c;
    logic [23:0] v;
    logic [3:0]  mask;

    rst = 1'b1; cmd_valid = 1'b0; cmd = '0; addr = '0; dbg_set = '0; dbg_way = '0;
    repeat (3) @(negedge clk);
    check("rst_l2_valid", l2_valid, 0);
    check("rst_l2_addr", l2_addr, 0);
    check("rst_ready", cmd_ready, 0);
    rst = 1'b0;
    count_walk(n);
    check("reset_walk_len", n, 64);
    check("rst_counters", {hits, misses, fetches, snoops}, 0);
    for (int w = 0; w < 4; w++) begin
      rd_dbg(1, w, v);
      check("rst_dbg_set1", v, mk(0, 0, 3 - w));
    end

    // First fetch: miss into way 0
    issue(3'd0, 32'h0000_1040, lat, seen, l2a, l2c);
    check("fetch1_lat", lat, 3);
    check("fetch1_l2_seen", seen, 1);
    check("fetch1_l2_addr", l2a, 32'h0000_1040);
    check("fetch1_l2_cmd", l2c, 2);
    check("fetch1_cnt", {hits, misses, fetches}, {32'd0, 32'd1, 32'd1});
    rd_dbg(1, 0, v); check("fetch1_w0", v, mk(1, 2, 0));
    rd_dbg(1, 1, v); check("fetch1_w1", v, mk(0, 0, 3));
    rd_dbg(1, 3, v); check("fetch1_w3", v, mk(0, 0, 1));

    // Same line again: hit
    issue(3'd0, 32'h0000_1040, lat, seen, l2a, l2c);
    check("fetch2_lat", lat, 3);
    check("fetch2_no_l2", seen, 0);
    check("fetch2_cnt", {hits, misses, fetches}, {32'd1, 32'd1, 32'd2});
    rd_dbg(1, 0, v); check("fetch2_w0", v, mk(1, 2, 0));

    // Tags 2..5 into set 1; tag 5 evicts LRU way 0 (tag 1)
    for (int t = 2; t <= 5; t++) issue(3'd0, (t << 12) | 32'h40, lat, seen, l2a, l2c);
    check("evict_l2_addr", l2a, 32'h0000_5040);
    check("evict_cnt", {hits, misses, fetches}, {32'd1, 32'd5, 32'd6});
    rd_dbg(1, 0, v); check("evict_w0", v, mk(5, 2, 0));
    rd_dbg(1, 1, v); check("evict_w1", v, mk(2, 2, 3));
    rd_dbg(1, 2, v); check("evict_w2", v, mk(3, 2, 2));
    rd_dbg(1, 3, v); check("evict_w3", v, mk(4, 2, 1));
    mask = '0;
    for (int w = 0; w < 4; w++) begin
      rd_dbg(1, w, v);
      mask[v[1:0]] = 1'b1;
    end
    check("evict_age_perm", mask, 4'hF);

    // Snoops
    issue(3'd2, 32'h0000_5040, lat, seen, l2a, l2c);
    check("snrd_lat", lat, 2);
    check("snrd_no_l2", seen, 0);
    rd_dbg(1, 0, v); check("snrd_shared", v, mk(5, 1, 0));
    issue(3'd2, 32'h0000_5040, lat, seen, l2a, l2c);
    rd_dbg(1, 0, v); check("snrd_shared_again", v, mk(5, 1, 0));
    issue(3'd1, 32'h0000_9040, lat, seen, l2a, l2c);
    rd_dbg(1, 0, v); check("sninv_miss", v, mk(5, 1, 0));
    issue(3'd1, 32'h0000_5040, lat, seen, l2a, l2c);
    check("sninv_no_l2", seen, 0);
    rd_dbg(1, 0, v); check("sninv_w0", v, mk(5, 0, 0));
    rd_dbg(1, 1, v); check("sninv_w1", v, mk(2, 2, 3));
    rd_dbg(1, 2, v); check("sninv_w2", v, mk(3, 2, 2));
    rd_dbg(1, 3, v); check("sninv_w3", v, mk(4, 2, 1));
    check("snoop_cnt", {hits, misses, fetches, snoops}, {32'd1, 32'd5, 32'd6, 32'd4});

    // Invalidated line must miss and refill way 0
    issue(3'd0, 32'h0000_5040, lat, seen, l2a, l2c);
    check("refetch_l2_seen", seen, 1);
    check("refetch_cnt", {hits, misses, fetches}, {32'd1, 32'd6, 32'd7});
    rd_dbg(1, 0, v); check("refetch_w0", v, mk(5, 2, 0));

    // NOP
    issue(3'd6, 32'h0000_2040, lat, seen, l2a, l2c);
    check("nop_lat", lat, 2);
    check("nop_no_l2", seen, 0);
    check("nop_cnt", {hits, misses, fetches, snoops}, {32'd1, 32'd6, 32'd7, 32'd4});
    rd_dbg(1, 1, v); check("nop_w1", v, mk(2, 2, 3));

    // CLEAR command: LOOKUP + 64-set walk
    issue(3'd3, 32'h0, lat, seen, l2a, l2c);
    check("clear_lat", lat, 66);
    check("clear_cnt", {hits, misses, fetches, snoops}, {32'd1, 32'd6, 32'd7, 32'd4});
    rd_dbg(1, 0, v); check("clear_w0", v, mk(0, 0, 3));
    rd_dbg(1, 3, v); check("clear_w3", v, mk(0, 0, 0));

    // Reset in the middle of a CLEAR walk
    issue(3'd0, 32'h0000_1040, lat, seen, l2a, l2c);
    cmd_valid = 1'b1; cmd = 3'd3; addr = '0;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    count_walk(n);
    check("midclear_walk_len", n, 64);
    check("midclear_counters", {hits, misses, fetches, snoops}, 0);
    for (int w = 0; w < 4; w++) begin
      rd_dbg(1, w, v);
      check("midclear_dbg_set1", v, mk(0, 0, 3 - w));
    end
    rd_dbg(63, 2, v); check("midclear_dbg_set63", v, mk(0, 0, 1));

    issue(3'd0, 32'h0000_1040, lat, seen, l2a, l2c);
    check("postrst_l2_seen", seen, 1);
    check("postrst_cnt", {hits, misses, fetches}, {32'd0, 32'd1, 32'd1});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
